// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC register sequencer: state encoding,
// default command address, default register walk and register index names.
package rtc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_XFER = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   localparam logic [7:0] CMD_ADDR_DEF = 8'hF0;

   // Entry i sits at bits [i*8 +: 8]; index 0 is the first register walked.
   localparam logic [71:0] ADDR_TABLE_DEF =
      {8'h43, 8'h42, 8'h41, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

   localparam int IDX_SEG     = 0;
   localparam int IDX_MIN     = 1;
   localparam int IDX_HOR     = 2;
   localparam int IDX_DIA     = 3;
   localparam int IDX_MES     = 4;
   localparam int IDX_ANO     = 5;
   localparam int IDX_TMR_SEG = 6;
   localparam int IDX_TMR_MIN = 7;
   localparam int IDX_TMR_HOR = 8;

endpackage

// File: rtl/rtc_wait_timer.sv
// Per-transaction wait counter. It counts enabled cycles since the last clear
// and flags the cycle in which the wait reaches LIMIT cycles.
module rtc_wait_timer #(
   parameter int unsigned LIMIT = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + 1'b1;
      end
   end

   // The current cycle is the LIMIT-th one spent waiting.
   assign expired = en && ((32'(count) + 32'd1) >= LIMIT);

endmodule

// File: rtl/rtc_seq_ctrl.sv
// RTC register sequencer: one command transaction, then a walk over an address
// table reading or writing each register, with timeout, abort and auto-repeat.
module rtc_seq_ctrl
   import rtc_pkg::*;
#(
   parameter int                         N_REGS     = 9,
   parameter int                         ADDR_W     = 8,
   parameter int                         DATA_W     = 8,
   parameter logic [ADDR_W-1:0]          CMD_ADDR   = CMD_ADDR_DEF,
   parameter logic [N_REGS*ADDR_W-1:0]   ADDR_TABLE = ADDR_TABLE_DEF,
   parameter int unsigned                TIMEOUT    = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic              repeat_en,
   input  logic              abort,
   input  logic              fin,
   input  logic [DATA_W-1:0] bus_din,
   input  logic [DATA_W-1:0] wr_data,
   output logic              bus_req,
   output logic              bus_cmd,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_dout,
   output logic [3:0]        reg_idx,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [3:0]        rd_idx,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        dbg_state
);

   localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

   // Bus handshake: bus_req stays high for the whole CMD/XFER phase; the
   // engine completes the addressed transaction by pulsing fin for one cycle,
   // and the sequencer presents the next address in the following cycle.
   state_t            state, state_n;
   logic              mode_q;
   logic              in_bus;
   logic              last;
   logic              accept_fin;
   logic              expired;
   logic [ADDR_W-1:0] table_addr;

   assign in_bus     = (state == ST_CMD) || (state == ST_XFER);
   assign last       = (reg_idx == LAST_IDX);
   assign accept_fin = in_bus && fin && !abort;

   rtc_wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (!in_bus || fin),
      .en      (in_bus),
      .expired (expired)
   );

   always_comb begin
      table_addr = '0;
      for (int i = 0; i < N_REGS; i++) begin
         if (reg_idx == 4'(i)) table_addr = ADDR_TABLE[i*ADDR_W +: ADDR_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_n;
   end

   // abort outranks fin, which outranks the timeout.
   always_comb begin
      state_n  = state;
      bus_req  = 1'b0;
      bus_cmd  = 1'b0;
      bus_we   = 1'b0;
      bus_addr = '0;
      bus_dout = '0;
      case (state)
         ST_IDLE: begin
            if (start) state_n = ST_CMD;
         end
         ST_CMD: begin
            bus_req  = 1'b1;
            bus_cmd  = 1'b1;
            bus_we   = 1'b1;
            bus_addr = CMD_ADDR;
            if (abort)        state_n = ST_IDLE;
            else if (fin)     state_n = ST_XFER;
            else if (expired) state_n = ST_ERR;
         end
         ST_XFER: begin
            bus_req  = 1'b1;
            bus_we   = mode_q;
            bus_addr = table_addr;
            bus_dout = mode_q ? wr_data : '0;
            if (abort)        state_n = ST_IDLE;
            else if (fin)     state_n = last ? ST_DONE : ST_XFER;
            else if (expired) state_n = ST_ERR;
         end
         ST_DONE: begin
            state_n = (repeat_en && !abort) ? ST_CMD : ST_IDLE;
         end
         ST_ERR: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reg_idx  <= '0;
         mode_q   <= 1'b0;
         err      <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_idx   <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (state == ST_IDLE && start) begin
            mode_q  <= mode;
            err     <= 1'b0;
            reg_idx <= '0;
         end
         if (state_n == ST_ERR) err <= 1'b1;
         if (state == ST_XFER && accept_fin) begin
            if (!mode_q) begin
               rd_valid <= 1'b1;
               rd_data  <= bus_din;
               rd_idx   <= reg_idx;
            end
            if (!last) reg_idx <= reg_idx + 4'd1;
         end
         if (state == ST_DONE && repeat_en && !abort) reg_idx <= '0;
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign dbg_state = state;

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// Bench for rtc_seq_ctrl: a bus-engine driver answers requests with fin, a
// monitor logs completed transactions, and a table-driven model predicts them.
module tb_rtc_seq_ctrl;

   localparam int N   = 9;
   localparam int TMO = 1023;

   logic       clk = 1'b0;
   logic       reset, start, mode, repeat_en, abort, fin;
   logic [7:0] bus_din, wr_data, wr_base;
   logic       bus_req, bus_cmd, bus_we, rd_valid, busy, done, err;
   logic [7:0] bus_addr, bus_dout, rd_data;
   logic [3:0] reg_idx, rd_idx;
   logic [2:0] dbg_state;
   logic [38:0] outs;

   int n_checks, n_pass, done_cnt;

   logic [7:0]  tbl [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   logic [17:0] obs_q[$];
   logic [17:0] exp_q[$];
   logic [11:0] obs_rd_q[$];
   logic [11:0] exp_rd_q[$];
   logic [7:0]  din_log[$];

   always #5 clk = ~clk;

   assign wr_data = wr_base + {4'h0, reg_idx};
   assign outs = {bus_req, bus_cmd, bus_we, bus_addr, bus_dout, reg_idx,
                  rd_valid, rd_data, rd_idx, busy, done, err};

   rtc_seq_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .repeat_en (repeat_en),
      .abort     (abort),
      .fin       (fin),
      .bus_din   (bus_din),
      .wr_data   (wr_data),
      .bus_req   (bus_req),
      .bus_cmd   (bus_cmd),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_dout  (bus_dout),
      .reg_idx   (reg_idx),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_idx    (rd_idx),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   // A transaction completes when the engine's fin meets an active request without abort.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus_req && fin && !abort) obs_q.push_back({bus_cmd, bus_we, bus_addr, bus_dout});
         if (rd_valid) obs_rd_q.push_back({rd_idx, rd_data});
         if (done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      obs_q.delete(); exp_q.delete(); obs_rd_q.delete(); exp_rd_q.delete(); din_log.delete();
      done_cnt = 0;
   endtask

   task automatic begin_burst(input bit m);
      mode  = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Bus engine: answer n_txn requests, each after a random wait in [dmin,dmax].
   task automatic serve(input int n_txn, input int dmin, input int dmax, input bit poke);
      for (int t = 0; t < n_txn; t++) begin
         int d = int'($urandom_range(dmax, dmin));
         for (int c = 0; c < d; c++) begin
            if (poke) start = 1'($urandom_range(0, 1));
            tick();
         end
         start   = 1'b0;
         fin     = 1'b1;
         bus_din = 8'($urandom);
         din_log.push_back(bus_din);
         tick();
         fin = 1'b0;
      end
   endtask

   // Transaction t=0 is the command; t>=1 targets table entry t-1.
   task automatic build_model(input bit m, input int n_txn);
      exp_q.delete();
      exp_rd_q.delete();
      for (int t = 0; t < n_txn; t++) begin
         if (t == 0) begin
            exp_q.push_back({1'b1, 1'b1, 8'hF0, 8'h00});
         end else begin
            exp_q.push_back({1'b0, m, tbl[t-1], m ? (wr_base + 8'(t-1)) : 8'h00});
            if (!m) exp_rd_q.push_back({4'(t-1), din_log[t]});
         end
      end
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if (outs !== 39'd0) $display("FAIL reset_outs: got %h want 0", outs); else n_pass++;
      @(posedge clk); #1 reset = 1'b0;
      tick();
      n_checks++;
      if (outs !== 39'd0) $display("FAIL idle_outs: got %h want 0", outs); else n_pass++;
   endtask

   task automatic test_spurious();
      for (int i = 0; i < 8; i++) begin
         fin     = 1'($urandom_range(0, 1));
         bus_din = 8'($urandom);
         tick();
         n_checks++;
         if ({busy, bus_req, rd_valid} !== 3'b000)
            $display("FAIL spurious_fin: got %b want 000", {busy, bus_req, rd_valid});
         else n_pass++;
      end
      fin = 1'b0;
   endtask

   task automatic test_bursts();
      for (int b = 0; b < 6; b++) begin
         bit m;
         int dmin, dmax;
         bit poke;
         if (b == 0) begin m = 1'b0; dmin = 3; dmax = 3; poke = 1'b0; wr_base = 8'h10; end
         else if (b == 1) begin m = 1'b1; dmin = 3; dmax = 3; poke = 1'b0; wr_base = 8'h10; end
         else begin
            m = 1'($urandom_range(0, 1)); dmin = 0; dmax = 3; poke = 1'b1; wr_base = 8'($urandom);
         end
         clear_logs();
         begin_burst(m);
         serve(N + 1, dmin, dmax, poke);
         n_checks++;
         if ({done, busy, bus_req} !== 3'b110)
            $display("FAIL burst%0d_done_cycle: got %b want 110", b, {done, busy, bus_req});
         else n_pass++;
         tick();
         n_checks++;
         if ({done, busy} !== 2'b00)
            $display("FAIL burst%0d_idle_after: got %b want 00", b, {done, busy});
         else n_pass++;
         build_model(m, N + 1);
         n_checks++;
         if (obs_q.size() != exp_q.size())
            $display("FAIL burst%0d_txn_count: got %0d want %0d", b, obs_q.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
               $display("FAIL burst%0d_txn%0d: got %h want %h", b, i, obs_q[i], exp_q[i]);
            else n_pass++;
         end
         n_checks++;
         if (obs_rd_q.size() != exp_rd_q.size())
            $display("FAIL burst%0d_rd_count: got %0d want %0d", b, obs_rd_q.size(), exp_rd_q.size());
         else n_pass++;
         for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++) begin
            n_checks++;
            if (obs_rd_q[i] !== exp_rd_q[i])
               $display("FAIL burst%0d_rd%0d: got %h want %h", b, i, obs_rd_q[i], exp_rd_q[i]);
            else n_pass++;
         end
         n_checks++;
         if (done_cnt != 1) $display("FAIL burst%0d_done_pulses: got %0d want 1", b, done_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_min_burst();
      int  cnt;
      bit  m;
      m = 1'($urandom_range(0, 1));
      wr_base = 8'($urandom);
      clear_logs();
      begin_burst(m);
      bus_din = 8'($urandom);
      for (int t = 0; t <= N; t++) din_log.push_back(bus_din);
      fin = 1'b1;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         tick();
      end
      fin = 1'b0;
      n_checks++;
      if (cnt != N + 2) $display("FAIL min_burst_len: got %0d want %0d", cnt, N + 2); else n_pass++;
      build_model(m, N + 1);
      n_checks++;
      if (obs_q.size() != exp_q.size())
         $display("FAIL min_burst_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) $display("FAIL min_burst_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (obs_rd_q.size() != exp_rd_q.size())
         $display("FAIL min_burst_rd_count: got %0d want %0d", obs_rd_q.size(), exp_rd_q.size());
      else n_pass++;
   endtask

   task automatic test_timeout();
      int cnt;
      clear_logs();
      begin_burst(1'b0);
      serve(5, 1, 2, 1'b0);
      n_checks++;
      if (bus_addr !== 8'h25) $display("FAIL timeout_addr: got %h want 25", bus_addr); else n_pass++;
      cnt = 0;
      while (bus_req && cnt < TMO + 50) begin
         cnt++;
         tick();
      end
      n_checks++;
      if (cnt != TMO) $display("FAIL timeout_wait: got %0d want %0d", cnt, TMO); else n_pass++;
      n_checks++;
      if ({err, busy, done, bus_req} !== 4'b1100)
         $display("FAIL timeout_err_state: got %b want 1100", {err, busy, done, bus_req});
      else n_pass++;
      tick();
      n_checks++;
      if ({err, busy} !== 2'b10) $display("FAIL timeout_idle: got %b want 10", {err, busy}); else n_pass++;
      fin = 1'b1;
      repeat (4) tick();
      fin = 1'b0;
      n_checks++;
      if ({err, busy} !== 2'b10) $display("FAIL err_sticky: got %b want 10", {err, busy}); else n_pass++;
      n_checks++;
      if (done_cnt != 0) $display("FAIL timeout_done: got %0d want 0", done_cnt); else n_pass++;
      begin_burst(1'b0);
      n_checks++;
      if ({err, bus_cmd, busy} !== 3'b011)
         $display("FAIL err_clear_on_start: got %b want 011", {err, bus_cmd, busy});
      else n_pass++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({busy, err} !== 2'b00) $display("FAIL abort_in_cmd: got %b want 00", {busy, err}); else n_pass++;
   endtask

   task automatic test_abort();
      clear_logs();
      begin_burst(1'b0);
      serve(3, 1, 3, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
      n_checks++;
      if (reg_idx !== 4'd2) $display("FAIL abort_idx: got %0d want 2", reg_idx); else n_pass++;
      fin     = 1'b1;
      abort   = 1'b1;
      bus_din = 8'($urandom);
      tick();
      fin   = 1'b0;
      abort = 1'b0;
      n_checks++;
      if ({busy, bus_req, rd_valid, done, err} !== 5'b00000)
         $display("FAIL abort_result: got %b want 00000", {busy, bus_req, rd_valid, done, err});
      else n_pass++;
      tick();
      build_model(1'b0, 3);
      n_checks++;
      if (obs_rd_q.size() != 2) $display("FAIL abort_rd_count: got %0d want 2", obs_rd_q.size()); else n_pass++;
      for (int i = 0; i < exp_rd_q.size() && i < obs_rd_q.size(); i++) begin
         n_checks++;
         if (obs_rd_q[i] !== exp_rd_q[i]) $display("FAIL abort_rd%0d: got %h want %h", i, obs_rd_q[i], exp_rd_q[i]);
         else n_pass++;
      end
      n_checks++;
      if (done_cnt != 0) $display("FAIL abort_done: got %0d want 0", done_cnt); else n_pass++;
   endtask

   task automatic test_repeat_reset();
      clear_logs();
      repeat_en = 1'b1;
      begin_burst(1'b0);
      serve(N + 1, 1, 1, 1'b0);
      n_checks++;
      if ({busy, bus_req, done} !== 3'b101)
         $display("FAIL repeat_done_cycle: got %b want 101", {busy, bus_req, done});
      else n_pass++;
      tick();
      repeat_en = 1'b0;
      n_checks++;
      if ({busy, bus_req, bus_cmd, bus_addr} !== {3'b111, 8'hF0})
         $display("FAIL repeat_cmd: got %b %h want 111 f0", {busy, bus_req, bus_cmd}, bus_addr);
      else n_pass++;
      serve(N + 1, 1, 1, 1'b0);
      tick();
      n_checks++;
      if ({obs_rd_q.size() == 2 * N, done_cnt == 2, busy} !== 3'b110)
         $display("FAIL repeat_totals: rd %0d done %0d busy %b want 18 2 0", obs_rd_q.size(), done_cnt, busy);
      else n_pass++;
      clear_logs();
      begin_burst(1'b1);
      serve(4, 1, 1, 1'b0);
      n_checks++;
      if (bus_req !== 1'b1) $display("FAIL reset_pre_xfer: got %b want 1", bus_req); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (outs !== 39'd0) $display("FAIL reset_mid_xfer: got %h want 0", outs); else n_pass++;
      tick();
      reset = 1'b0;
      tick();
      n_checks++;
      if (outs !== 39'd0) $display("FAIL reset_release: got %h want 0", outs); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 1'b0; repeat_en = 1'b0; abort = 1'b0;
      fin = 1'b0; bus_din = 8'h00; wr_base = 8'h10;
      n_checks = 0; n_pass = 0; done_cnt = 0;
      test_reset();
      test_spurious();
      test_bursts();
      test_min_burst();
      test_timeout();
      test_abort();
      test_repeat_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
